instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 35 +++
 rtl/instr_fetch_nextpc.sv | 54 +++++
 rtl/instr_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared RISC constants for the fetch stage: vectors, instruction fields, FSM and mux encodings.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'd0;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'd4;
  localparam logic [31:0] XADR_VEC_DEF  = 32'd8;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RC_MSB     = 25;
  localparam int unsigned RC_LSB     = 21;
  localparam int unsigned RA_MSB     = 20;
  localparam int unsigned RA_LSB     = 16;
  localparam int unsigned LIT_MSB    = 15;
  localparam int unsigned LIT_LSB    = 0;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFlush
  } fetch_state_e;

  typedef enum logic [2:0] {
    SelSeq,
    SelHold,
    SelRedir,
    SelIrq,
    SelIllop
  } nextpc_sel_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_nextpc.sv
// Next-pc priority mux: illop/fault, irq, redirect, stall, then sequential pc+4.
module instr_fetch_nextpc
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 128,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic [31:0] i_pc,
  input  logic        i_run,
  input  logic        i_f_valid,
  input  logic        i_illop,
  input  logic        i_irq,
  input  logic        i_redir_valid,
  input  logic [31:0] i_redir_pc,
  input  logic        i_stall,
  output logic [31:0] o_next_pc,
  output nextpc_sel_e o_sel,
  output logic        o_oor
);

  localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_WORDS);
  localparam logic [31:0] IRQ_SPAN  = XADR_VEC + 32'd4 - RESET_VEC;

  logic w_irq_window;
  logic w_irq_take;
  logic unused_redir_lsb;

  assign o_oor = (i_pc >= ROM_BYTES) || (i_pc[1:0] != 2'b00);
  // Offset compare keeps the window check unsigned and free of constant-true terms.
  assign w_irq_window = (i_pc - RESET_VEC) <= IRQ_SPAN;
  assign w_irq_take = i_irq && i_run && i_f_valid && !w_irq_window;
  assign unused_redir_lsb = ^i_redir_pc[1:0];

  always_comb begin
    o_sel     = SelSeq;
    o_next_pc = i_pc + 32'd4;
    if (i_illop || o_oor) begin
      o_sel     = SelIllop;
      o_next_pc = ILLOP_VEC;
    end else if (w_irq_take) begin
      o_sel     = SelIrq;
      o_next_pc = XADR_VEC;
    end else if (i_redir_valid) begin
      o_sel     = SelRedir;
      o_next_pc = {i_redir_pc[31:2], 2'b00};
    end else if (i_stall) begin
      o_sel     = SelHold;
      o_next_pc = i_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives pc to a combinational ROM and registers {instr, pc} one cycle later.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 128,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  input  logic [31:0] i_id,
  input  logic        i_stall,
  input  logic        i_redir_valid,
  input  logic [31:0] i_redir_pc,
  input  logic        i_illop,
  input  logic        i_irq,
  output logic        o_f_valid,
  output logic [31:0] o_f_instr,
  output logic [31:0] o_f_pc,
  output logic [31:0] o_xp_pc,
  output logic        o_fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_f_instr;
  logic [31:0]  r_f_pc;
  logic [31:0]  r_xp_pc;
  logic         r_f_valid;
  logic         r_fault;

  logic [31:0]  w_next_pc;
  nextpc_sel_e  w_sel;
  logic         w_oor;

  instr_fetch_nextpc #(
    .ROM_WORDS (ROM_WORDS),
    .RESET_VEC (RESET_VEC),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_nextpc (
    .i_pc          (r_pc),
    .i_run         (r_state == StRun),
    .i_f_valid     (r_f_valid),
    .i_illop       (i_illop),
    .i_irq         (i_irq),
    .i_redir_valid (i_redir_valid),
    .i_redir_pc    (i_redir_pc),
    .i_stall       (i_stall),
    .o_next_pc     (w_next_pc),
    .o_sel         (w_sel),
    .o_oor         (w_oor)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StBoot;
      r_pc      <= RESET_VEC;
      r_f_valid <= 1'b0;
      r_f_instr <= 32'd0;
      r_f_pc    <= 32'd0;
      r_xp_pc   <= 32'd0;
      r_fault   <= 1'b0;
    end else if (r_state == StBoot) begin
      r_pc      <= RESET_VEC;
      r_f_valid <= 1'b0;
      r_fault   <= 1'b0;
      r_state   <= StRun;
    end else begin
      r_pc    <= w_next_pc;
      r_fault <= w_oor;
      // Every redirecting case squashes the word fetched this cycle via FLUSH.
      unique case (w_sel)
        SelIllop: begin
          r_f_valid <= 1'b0;
          r_xp_pc   <= r_f_pc + 32'd4;
          r_state   <= StFlush;
        end
        SelIrq: begin
          r_f_valid <= 1'b0;
          r_xp_pc   <= r_f_pc;
          r_state   <= StFlush;
        end
        SelRedir: begin
          r_f_valid <= 1'b0;
          r_state   <= StFlush;
        end
        SelHold: ;
        default: begin
          r_f_instr <= i_id;
          r_f_pc    <= r_pc;
          r_f_valid <= 1'b1;
          r_state   <= StRun;
        end
      endcase
    end
  end

  assign o_pc      = r_pc;
  assign o_f_valid = r_f_valid;
  assign o_f_instr = r_f_instr;
  assign o_f_pc    = r_f_pc;
  assign o_xp_pc   = r_xp_pc;
  assign o_fault   = r_fault;

endmodule
